// File: rtl/spi_pkg.sv
// Shared SPI controller types and the LSU-visible register map.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  localparam int SPI_CSR_BUSY_BIT = 0;
  localparam int SPI_CSR_CS_BIT   = 2;

  localparam logic [31:0] SPI_COMMAND_ADDR = 32'h800;
  localparam logic [31:0] SPI_CSR_ADDR     = 32'h801;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider: counts clk cycles within a phase and strobes rise/fall.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_phase_high,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tc;

  assign w_tc = (r_div_cnt == DIV_TC);

  // Held at zero while idle so each transfer's first phase starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!i_run || w_tc) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_rise = i_run & ~i_phase_high & w_tc;
  assign o_fall = i_run &  i_phase_high & w_tc;

endmodule

// File: rtl/spi_controller.sv
// Mode-0, MSB-first, 8-bit SPI master behind the LSU SPI_COMMAND/SPI_CSR registers.
// Chip select is owned by software and passed straight through.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_trigger,
  input  logic [7:0] spi_command,
  input  logic       spi_cs_ctl,
  output logic       spi_busy,
  output logic [7:0] spi_response,
  output logic       spi_done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  spi_state_e r_state;
  spi_state_e w_state_nxt;

  logic [6:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_sclk;
  logic       r_mosi;
  logic [7:0] r_response;

  logic w_rise;
  logic w_fall;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .i_run        (r_state != IDLE),
    .i_phase_high (r_state == HIGH),
    .o_rise       (w_rise),
    .o_fall       (w_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (spi_trigger) w_state_nxt = LOW;
      LOW:  if (w_rise)      w_state_nxt = HIGH;
      HIGH: if (w_fall)      w_state_nxt = (r_bit_cnt == 3'd7) ? IDLE : LOW;
      default:               w_state_nxt = IDLE;
    endcase
  end

  // Triggers outside IDLE (including the completion edge) fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_response <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (spi_trigger) begin
            r_tx_shift <= spi_command[6:0];
            r_mosi     <= spi_command[7];
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_sclk     <= 1'b1;
            r_rx_shift <= {r_rx_shift[6:0], spi_miso};
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              r_response <= r_rx_shift;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_mosi     <= r_tx_shift[6];
              r_tx_shift <= {r_tx_shift[5:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_busy     = r_busy;
  assign spi_done     = r_done;
  assign spi_sclk     = r_sclk;
  assign spi_mosi     = r_mosi;
  assign spi_response = r_response;
  assign spi_cs_n     = spi_cs_ctl;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: one instance at CLK_DIV=4 and one at CLK_DIV=1,
// each transfer checked against a bit-level slave model.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       sel = 1'b0;
  logic       cs_ctl = 1'b1;
  logic       miso = 1'b0;
  logic [7:0] command = 8'h00;

  always #5 clk = ~clk;

  logic       trig4, busy4, done4, sclk4, mosi4, csn4;
  logic       trig1, busy1, done1, sclk1, mosi1, csn1;
  logic [7:0] resp4, resp1;

  assign trig4 = trig & ~sel;
  assign trig1 = trig & sel;

  spi_controller #(.CLK_DIV(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .spi_trigger  (trig4),
    .spi_command  (command),
    .spi_cs_ctl   (cs_ctl),
    .spi_busy     (busy4),
    .spi_response (resp4),
    .spi_done     (done4),
    .spi_sclk     (sclk4),
    .spi_mosi     (mosi4),
    .spi_miso     (miso),
    .spi_cs_n     (csn4)
  );

  spi_controller #(.CLK_DIV(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .spi_trigger  (trig1),
    .spi_command  (command),
    .spi_cs_ctl   (cs_ctl),
    .spi_busy     (busy1),
    .spi_response (resp1),
    .spi_done     (done1),
    .spi_sclk     (sclk1),
    .spi_mosi     (mosi1),
    .spi_miso     (miso),
    .spi_cs_n     (csn1)
  );

  logic       busy, done, sclk, mosi;
  logic [7:0] resp;
  assign busy = sel ? busy1 : busy4;
  assign done = sel ? done1 : done4;
  assign sclk = sel ? sclk1 : sclk4;
  assign mosi = sel ? mosi1 : mosi4;
  assign resp = sel ? resp1 : resp4;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         t_start = 0;
  logic [7:0] last_resp [2] = '{8'h00, 8'h00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic start_xfer(input logic [7:0] cmd);
    trig    = 1'b1;
    command = cmd;
    @(negedge clk);
    trig    = 1'b0;
    t_start = cyc;
    check("start_busy", busy, 1);
    check("start_mosi", mosi, cmd[7]);
    check("start_sclk", sclk, 0);
  endtask

  // Slave model: presents bit (7-n) while SCLK is low before rise n, and the
  // inverted bit while SCLK is high, so only a sample taken at the rise is right.
  task automatic run_xfer(input logic [7:0] cmd, input logic [7:0] mb, input bit loopback,
                          input int extra_cyc, input int abort_bits);
    int         rises = 0;
    int         busy_cyc = 1;
    int         d;
    logic       prev = 1'b0;
    logic       rose, toggled;
    bit         finished = 1'b0;
    logic [7:0] exp_resp;
    d        = sel ? 1 : 4;
    exp_resp = loopback ? cmd : mb;
    for (int c = 1; c <= 40 * d + 20 && !finished; c++) begin
      if (loopback) miso = mosi;
      else if (!sclk && rises < 8) miso = mb[7 - rises];
      else if (sclk && rises > 0) miso = ~mb[8 - rises];
      if (extra_cyc != 0 && c == extra_cyc) begin
        trig    = 1'b1;
        command = 8'hFF;
      end
      @(negedge clk);
      trig = 1'b0;
      rose    = sclk && !prev;
      toggled = (sclk != prev);
      prev    = sclk;
      if (rose) begin
        if (rises < 8) check("mosi_bit", mosi, cmd[7 - rises]);
        rises++;
      end
      if (abort_bits != 0 && rises == abort_bits) begin
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_done", done, 0);
        check("abort_resp", resp, 8'h00);
        last_resp[0] = 8'h00;
        last_resp[1] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (busy) begin
        busy_cyc++;
        check("resp_hold", resp, last_resp[sel]);
        check("done_low_busy", done, 0);
        if (d == 1) check("sclk_half", toggled, 1);
      end else begin
        finished = 1'b1;
        check("busy_len", busy_cyc, 16 * d);
        check("done_pulse", done, 1);
        check("response", resp, exp_resp);
        check("rise_count", rises, 8);
        last_resp[sel] = exp_resp;
      end
    end
    check("timeout", finished, 1);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] mb, input bit loopback,
                      input int extra_cyc);
    start_xfer(cmd);
    run_xfer(cmd, mb, loopback, extra_cyc, 0);
    @(negedge clk);
    check("done_clear", done, 0);
    check("idle_busy", busy, 0);
    check("idle_sclk", sclk, 0);
  endtask

  initial begin
    logic [7:0] c1, c2, m1, m2;
    int         t1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_busy", busy, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_done", done, 0);
      check("rst_resp", resp, 8'h00);
    end
    sel    = 1'b0;
    cs_ctl = 1'b1;
    #1;
    check("cs_hi4", csn4, 1);
    check("cs_hi1", csn1, 1);
    cs_ctl = 1'b0;
    #1;
    check("cs_lo4", csn4, 0);
    check("cs_lo1", csn1, 0);
    @(negedge clk);

    start_xfer(8'h5A);
    run_xfer(8'h5A, 8'hF0, 1'b0, 0, 3);
    check("post_abort_busy", busy, 0);

    xfer(8'hA5, 8'h00, 1'b1, 0);
    xfer(8'h3C, 8'hC3, 1'b0, 0);

    xfer(8'h00, 8'h96, 1'b0, 10);
    repeat (20) @(negedge clk);
    check("ignored_busy", busy, 0);
    check("ignored_sclk", sclk, 0);
    check("ignored_resp", resp, 8'h96);

    for (int i = 0; i < 5; i++) xfer(8'($urandom), 8'($urandom), 1'b0, 0);

    sel = 1'b1;
    @(negedge clk);
    c1 = 8'($urandom);
    c2 = 8'($urandom);
    m1 = 8'($urandom);
    m2 = 8'($urandom);
    start_xfer(c1);
    t1 = t_start;
    run_xfer(c1, m1, 1'b0, 0, 0);
    start_xfer(c2);
    check("b2b_gap", t_start - t1, 17);
    run_xfer(c2, m2, 1'b0, 0, 0);
    @(negedge clk);
    check("b2b_done_clear", done, 0);

    for (int i = 0; i < 4; i++) xfer(8'($urandom), 8'($urandom), 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI master engine behind the load/store unit's SPI control registers (SPI_COMMAND at 0x800, SPI_CSR at 0x801). A one-cycle trigger from the LSU starts an 8-bit, MSB-first, mode-0 exchange. The controller drives SCLK/MOSI, samples MISO, reports BUSY in SPI_CSR bit 0 and returns the received byte as SPI_RESPONSE. Chip select is software-owned via SPI_CSR bit 2 and passed through unchanged.

## Interface
- CLK_DIV, 4, SCLK half-period in clk cycles; legal range 1–255
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spi_trigger  in  1  one-cycle start pulse from LSU (write to 0x800)
- spi_command  in  8  byte to transmit; sampled on the trigger cycle
- spi_cs_ctl  in  1  SPI_CSR bit 2 from LSU; 1 = deselected
- spi_busy  out  1  drives SPI_CSR bit 0; 1 while a transfer is in progress
- spi_response  out  8  last received byte; read by LSU at 0x800
- spi_done  out  1  one-cycle pulse when a transfer completes
- spi_sclk  out  1  serial clock, idle low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  1  chip select, active low

## Operation
- Reset values: spi_busy=0, spi_response=8'h00, spi_done=0, spi_sclk=0, spi_mosi=0, state=IDLE, counters=0.
- spi_cs_n = spi_cs_ctl, combinational. The controller never touches CS.
- States:
  - IDLE: on spi_trigger, load tx shift register with spi_command, set spi_busy=1, set mosi=spi_command[7], bit_cnt=0, div_cnt=0. Go to LOW.
  - LOW: sclk=0. When div_cnt==CLK_DIV-1: sclk<=1, rx_shift<={rx_shift[6:0],spi_miso}, div_cnt<=0. Go to HIGH.
  - HIGH: sclk=1. When div_cnt==CLK_DIV-1: sclk<=0, div_cnt<=0.
    - If bit_cnt==7: spi_response<=rx_shift, spi_busy<=0, spi_done<=1. Go to IDLE.
    - Otherwise: bit_cnt++, mosi<=next tx bit (MSB first). Go to LOW.
- spi_trigger while spi_busy=1 is ignored: no queuing, and the in-flight command and response are unaffected.
- spi_trigger on the same cycle as completion (the HIGH→IDLE edge) is ignored. The new transfer needs a trigger while in IDLE.
- spi_response changes only at transfer completion and holds its value otherwise.
- MISO is sampled on the clk edge that raises SCLK, so the slave must have valid data at the end of the low phase. No internal synchronizer.
- Reset mid-transfer aborts immediately to the reset values. A partial byte is discarded and spi_response is not updated.
- Counter widths: div_cnt is $clog2(CLK_DIV)+1 bits; bit_cnt is 3 bits.

## Timing
- Trigger sampled at edge T: spi_busy=1 and mosi=bit7 are visible after T. The first SCLK rise is at edge T+CLK_DIV.
- spi_busy stays high for exactly 16·CLK_DIV cycles. spi_done pulses in the first cycle after busy falls, and spi_response is valid in that same cycle.
- Earliest back-to-back restart: a trigger on the cycle spi_done is high starts the next transfer. Minimum period is 16·CLK_DIV+1 cycles.
- CLK_DIV=1: SCLK = clk/2 and the sequence is unchanged.
- All outputs are registered except spi_cs_n.

## Structure
- Package spi_pkg holds:
  - the state enum {IDLE, LOW, HIGH}
  - SPI_CSR_BUSY_BIT=0 and SPI_CSR_CS_BIT=2
  - the address constants SPI_COMMAND_ADDR=32'h800 and SPI_CSR_ADDR=32'h801, also used by the LSU
- One sub-module is natural: spi_clk_gen, which owns div_cnt and emits the rise/fall strobes. The FSM and shift registers stay in spi_controller.

## Test plan
- Reset then idle → spi_busy=0, spi_sclk=0, spi_response=00, spi_cs_n follows spi_cs_ctl (1 then 0).
- CLK_DIV=4, command 8'hA5, MISO loopback from MOSI → MOSI bits 1,0,1,0,0,1,0,1 across 8 SCLK pulses; busy high for 64 cycles; spi_done pulse; spi_response=A5.
- Command 8'h3C with MISO driving 8'hC3 → spi_response=C3; each bit is sampled at its SCLK rising edge.
- Second trigger with 8'hFF at cycle 10 of a transfer of 8'h00 → the transfer completes as 8'h00, then IDLE with no second transfer.
- rst asserted mid-transfer (after 3 bits) → outputs return to reset values asynchronously; spi_response stays at its prior value of 00; the next trigger works normally.
- CLK_DIV=1 with back-to-back trigger on the spi_done cycle → SCLK = clk/2, the second transfer starts 17 cycles after the first, and both responses are correct.
